// File: rtl/iq_freelist_ctrl_if.sv
// Free-list controller bus: allocate request/grant, free return, flush and the
// free-list RAM port. The controller takes the slave view; the environment
// driving requests and modelling the RAM takes the master view.
//   alloc_cnt_i  : entries requested this cycle (0..DISPATCH_W)
//   stall_o      : allocation refused this cycle
//   alloc_idx_o  : granted IQ indices, lane k in slice k
//   free_valid_i : per-lane free strobe
//   free_idx_i   : IQ indices being returned
//   flush_i      : every IQ entry becomes free
//   ram_raddr_o  : free-list RAM read addresses (head+k)
//   ram_rdata_i  : free-list RAM read data, combinational
//   ram_waddr_o  : free-list RAM write addresses
//   ram_wdata_o  : free-list RAM write data
//   ram_we_o     : free-list RAM write enables
//   free_cnt_o   : free entries held
//   ready_o      : initialisation complete
//   err_o        : sticky overflow / bad-request error
interface iq_freelist_ctrl_if #(
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 4,
  parameter int unsigned INDEX      = 4
);
  localparam int unsigned AllocCntW = $clog2(DISPATCH_W) + 1;

  logic [AllocCntW-1:0]        alloc_cnt_i;
  logic                        stall_o;
  logic [DISPATCH_W*INDEX-1:0] alloc_idx_o;
  logic [ISSUE_W-1:0]          free_valid_i;
  logic [ISSUE_W*INDEX-1:0]    free_idx_i;
  logic                        flush_i;
  logic [DISPATCH_W*INDEX-1:0] ram_raddr_o;
  logic [DISPATCH_W*INDEX-1:0] ram_rdata_i;
  logic [ISSUE_W*INDEX-1:0]    ram_waddr_o;
  logic [ISSUE_W*INDEX-1:0]    ram_wdata_o;
  logic [ISSUE_W-1:0]          ram_we_o;
  logic [INDEX:0]              free_cnt_o;
  logic                        ready_o;
  logic                        err_o;

  modport slave (
    input  alloc_cnt_i, free_valid_i, free_idx_i, flush_i, ram_rdata_i,
    output stall_o, alloc_idx_o, ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_we_o,
           free_cnt_o, ready_o, err_o
  );

  modport master (
    output alloc_cnt_i, free_valid_i, free_idx_i, flush_i, ram_rdata_i,
    input  stall_o, alloc_idx_o, ram_raddr_o, ram_waddr_o, ram_wdata_o, ram_we_o,
           free_cnt_o, ready_o, err_o
  );
endinterface

// File: rtl/iq_freelist_ctrl.sv
// Issue-queue free-list controller. The free list is a circular buffer of IQ
// indices held in an external RAM: allocation reads from head, frees write at
// tail. After reset or flush the RAM is refilled with 0..DEPTH-1, ISSUE_W
// entries per cycle, before allocation is allowed.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : request / grant / RAM signals (see iq_freelist_ctrl_if)
module iq_freelist_ctrl #(
  parameter int unsigned DISPATCH_W = 4,
  parameter int unsigned ISSUE_W    = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned INDEX      = 4
) (
  input logic               clk,
  input logic               reset_n,
  iq_freelist_ctrl_if.slave bus
);

  localparam int unsigned CntW = INDEX + 1;
  localparam logic [INDEX-1:0] LastGrp = INDEX'(DEPTH - ISSUE_W);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [INDEX-1:0]  head_q, head_d;
  logic [INDEX-1:0]  tail_q, tail_d;
  logic [INDEX-1:0]  init_ptr_q, init_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              err_q, err_d;

  logic                     stall;
  logic [ISSUE_W-1:0]       we;
  logic [ISSUE_W*INDEX-1:0] waddr;
  logic [ISSUE_W*INDEX-1:0] wdata;
  int unsigned              req, nalloc, nfree, sum;

  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      bus.ram_raddr_o[k*INDEX +: INDEX] = head_q + INDEX'(k);
    end
  end

  assign bus.alloc_idx_o = bus.ram_rdata_i;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    init_ptr_d = init_ptr_q;
    count_d    = count_q;
    err_d      = err_q;
    stall      = 1'b1;
    we         = '0;
    waddr      = '0;
    wdata      = '0;
    req        = 32'(bus.alloc_cnt_i);
    nalloc     = 0;
    nfree      = 0;
    sum        = 0;

    unique case (state_q)
      StInit: begin
        we = '1;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
          waddr[k*INDEX +: INDEX] = init_ptr_q + INDEX'(k);
          wdata[k*INDEX +: INDEX] = init_ptr_q + INDEX'(k);
        end
        if (bus.flush_i) begin
          init_ptr_d = '0;
        end else if (init_ptr_q == LastGrp) begin
          state_d = StRun;
          head_d  = '0;
          tail_d  = '0;
          count_d = CntW'(DEPTH);
        end else begin
          init_ptr_d = init_ptr_q + INDEX'(ISSUE_W);
        end
      end

      StRun: begin
        if (bus.flush_i) begin
          // Everything requested this cycle is dropped; INIT rebuilds the list.
          state_d    = StInit;
          init_ptr_d = '0;
        end else begin
          // Grant decision uses the registered count only: same-cycle frees
          // cannot satisfy this cycle's request.
          stall = (req > DISPATCH_W) || (req > 32'(count_q));
          if (req > DISPATCH_W) begin
            err_d = 1'b1;
          end
          nalloc = stall ? 0 : req;

          // Compact valid free lanes: the j-th set lane goes to write port j.
          for (int unsigned i = 0; i < ISSUE_W; i++) begin
            if (bus.free_valid_i[i]) begin
              for (int unsigned j = 0; j < ISSUE_W; j++) begin
                if (j == nfree) begin
                  we[j]                   = 1'b1;
                  waddr[j*INDEX +: INDEX] = tail_q + INDEX'(j);
                  wdata[j*INDEX +: INDEX] = bus.free_idx_i[i*INDEX +: INDEX];
                end
              end
              nfree = nfree + 1;
            end
          end

          sum = 32'(count_q) + nfree - nalloc;
          if (sum > DEPTH) begin
            err_d   = 1'b1;
            count_d = CntW'(DEPTH);
          end else begin
            count_d = CntW'(sum);
          end
          head_d = head_q + INDEX'(nalloc);
          tail_d = tail_q + INDEX'(nfree);
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit;
      head_q     <= '0;
      tail_q     <= '0;
      init_ptr_q <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      init_ptr_q <= init_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  assign bus.stall_o     = stall;
  // INIT drives all write enables; hold them off while reset is asserted.
  assign bus.ram_we_o    = we & {ISSUE_W{reset_n}};
  assign bus.ram_waddr_o = waddr;
  assign bus.ram_wdata_o = wdata;
  assign bus.ready_o     = (state_q == StRun);
  assign bus.free_cnt_o  = (state_q == StRun) ? count_q : '0;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_iq_freelist_ctrl.sv
// Bench for iq_freelist_ctrl: behavioural free-list RAM, a queue model of the
// free list, and a scoreboard of expected granted indices.
module tb_iq_freelist_ctrl;

  localparam int DW = 4;
  localparam int IW = 4;
  localparam int D  = 16;
  localparam int IX = 4;

  logic clk;
  logic reset_n;

  iq_freelist_ctrl_if #(.DISPATCH_W(DW), .ISSUE_W(IW), .INDEX(IX)) bus ();

  iq_freelist_ctrl #(.DISPATCH_W(DW), .ISSUE_W(IW), .DEPTH(D), .INDEX(IX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-list RAM: synchronous write, combinational read.
  logic [IX-1:0] ram [D];
  always @(posedge clk) begin
    for (int k = 0; k < IW; k++) begin
      if (bus.ram_we_o[k]) ram[bus.ram_waddr_o[k*IX +: IX]] <= bus.ram_wdata_o[k*IX +: IX];
    end
  end
  always_comb begin
    for (int k = 0; k < DW; k++) bus.ram_rdata_i[k*IX +: IX] = ram[bus.ram_raddr_o[k*IX +: IX]];
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  int m_q[$];
  int m_head, m_tail, m_iptr;
  bit m_run, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    bus.alloc_cnt_i = '0; bus.free_valid_i = '0; bus.free_idx_i = '0; bus.flush_i = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall_o), 32'd1);
    check("rst_we", 32'(bus.ram_we_o), 32'd0);
    check("rst_ready", 32'(bus.ready_o), 32'd0);
    check("rst_free_cnt", 32'(bus.free_cnt_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    m_run = 0; m_iptr = 0; m_head = 0; m_tail = 0; m_err = 0;
    m_q.delete();
  endtask

  // One cycle: drive, check combinational outputs, clock, update model, check state.
  task automatic step(input int n, input logic [3:0] fv, input logic [15:0] fidx, input logic fl);
    logic [15:0] era, ewa, ewd, lmask;
    logic [3:0]  ewe;
    logic        estall;
    int          nf, na;
    int          sb[$];
    @(negedge clk);
    bus.alloc_cnt_i  = 3'(n);
    bus.free_valid_i = fv;
    bus.free_idx_i   = fidx;
    bus.flush_i      = fl;
    #1;
    era = '0; ewa = '0; ewd = '0; lmask = '0; ewe = '0; nf = 0; na = 0;
    for (int k = 0; k < DW; k++) era[k*4 +: 4] = 4'((m_head + k) % D);
    if (!m_run) begin
      estall = 1'b1;
      ewe    = 4'hf;
      lmask  = '1;
      for (int k = 0; k < IW; k++) begin
        ewa[k*4 +: 4] = 4'(m_iptr + k);
        ewd[k*4 +: 4] = 4'(m_iptr + k);
      end
    end else if (fl) begin
      estall = 1'b1;
    end else begin
      estall = (n > DW) || (n > m_q.size());
      if (!estall) na = n;
      for (int i = 0; i < IW; i++) begin
        if (fv[i]) begin
          ewa[nf*4 +: 4]   = 4'((m_tail + nf) % D);
          ewd[nf*4 +: 4]   = fidx[i*4 +: 4];
          lmask[nf*4 +: 4] = 4'hf;
          nf++;
        end
      end
      ewe = 4'((1 << nf) - 1);
    end
    for (int a = 0; a < na; a++) sb.push_back(m_q.pop_front());

    check("stall", 32'(bus.stall_o), 32'(estall));
    check("raddr", 32'(bus.ram_raddr_o), 32'(era));
    check("we", 32'(bus.ram_we_o), 32'(ewe));
    if (ewe != 4'h0) begin
      check("waddr", 32'(bus.ram_waddr_o & lmask), 32'(ewa));
      check("wdata", 32'(bus.ram_wdata_o & lmask), 32'(ewd));
    end
    for (int a = 0; a < na; a++) begin
      check($sformatf("alloc_idx%0d", a), 32'(bus.alloc_idx_o[a*4 +: 4]), 32'(sb.pop_front()));
    end

    @(posedge clk);
    if (!m_run) begin
      if (fl) m_iptr = 0;
      else if (m_iptr == D - IW) begin
        m_run = 1; m_head = 0; m_tail = 0;
        m_q.delete();
        for (int i = 0; i < D; i++) m_q.push_back(i);
      end else m_iptr += IW;
    end else if (fl) begin
      m_run = 0; m_iptr = 0;
    end else begin
      if (n > DW) m_err = 1;
      m_head = (m_head + na) % D;
      m_tail = (m_tail + nf) % D;
      for (int i = 0; i < IW; i++) begin
        if (fv[i]) begin
          if (m_q.size() < D) m_q.push_back(int'(fidx[i*4 +: 4]));
          else m_err = 1;
        end
      end
    end
    #1;
    check("free_cnt", 32'(bus.free_cnt_o), m_run ? 32'(m_q.size()) : 32'd0);
    check("ready", 32'(bus.ready_o), 32'(m_run));
    check("err", 32'(bus.err_o), 32'(m_err));
  endtask

  initial begin
    int          n, room, cnt;
    logic [3:0]  fv;
    logic [15:0] fi;
    reset_n = 1'b0;
    do_reset();

    // Initialisation: four write groups, then 16 free entries.
    for (int i = 0; i < 4; i++) step(0, 4'h0, 16'h0, 1'b0);

    // Drain in groups of four, then a single request must stall.
    for (int i = 0; i < 4; i++) step(4, 4'h0, 16'h0, 1'b0);
    step(1, 4'h0, 16'h0, 1'b0);

    // Sparse free at empty list with a same-cycle request (stalls).
    step(1, 4'b1010, 16'h2070, 1'b0);
    step(2, 4'h0, 16'h0, 1'b0);

    // Walk head/tail to 14 with a full list.
    for (int i = 0; i < 3; i++) step(0, 4'hf, 16'(i * 16'h4444 + 16'h3210), 1'b0);
    for (int i = 0; i < 3; i++) step(4, 4'h0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 4'hf, 16'hfedc - 16'(i * 16'h4444), 1'b0);

    // Wrap: alloc 3 and free 3 together at head=tail=14.
    step(3, 4'b0111, 16'h0bcd, 1'b0);

    // Mixed random traffic that never overflows the list.
    for (int c = 0; c < 40; c++) begin
      n    = $urandom_range(0, 4);
      fv   = 4'($urandom);
      fi   = 16'($urandom);
      room = D - m_q.size() + ((n <= m_q.size()) ? n : 0);
      for (int i = 3; i >= 0; i--) if ($countones(fv) > room) fv[i] = 1'b0;
      step(n, fv, fi, 1'b0);
    end

    // Bring the count to 5, then flush with requests that must be dropped.
    while (m_q.size() > 5) begin
      cnt = m_q.size() - 5;
      step((cnt > 4) ? 4 : cnt, 4'h0, 16'h0, 1'b0);
    end
    while (m_q.size() < 5) begin
      cnt = 5 - m_q.size();
      step(0, 4'((1 << ((cnt > 4) ? 4 : cnt)) - 1), 16'h4321, 1'b0);
    end
    step(2, 4'b0011, 16'h1234, 1'b1);

    // INIT rerun with a flush inside INIT and a reset pulse mid-INIT.
    step(0, 4'h0, 16'h0, 1'b0);
    step(0, 4'h0, 16'h0, 1'b1);
    step(0, 4'h0, 16'h0, 1'b0);
    step(0, 4'h0, 16'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 4'h0, 16'h0, 1'b0);
    step(4, 4'h0, 16'h0, 1'b0);

    // Overflow at a full list sets the sticky error; an oversize request also stalls.
    step(0, 4'hf, 16'h3210, 1'b0);
    step(0, 4'b0001, 16'h0005, 1'b0);
    step(0, 4'h0, 16'h0, 1'b0);
    step(5, 4'h0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/iq_freelist_ctrl.md
IQ_FREELIST_CTRL -- requirements
Module: iq_freelist_ctrl

Interface
REQ-001 Parameter DISPATCH_W, default 4, is the number of allocate lanes per cycle.
REQ-002 Parameter ISSUE_W, default 4, is the number of free lanes per cycle.
REQ-003 Parameter DEPTH, default 16, is the number of issue-queue entries; it SHALL be a power of 2 and a multiple of ISSUE_W.
REQ-004 Parameter INDEX, default 4, equals log2(DEPTH).
REQ-005 Ports SHALL be, in this order:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alloc_cnt_i  in  log2(DISPATCH_W)+1  entries requested this cycle (0..DISPATCH_W).
- stall_o  out  1  allocation refused this cycle.
- alloc_idx_o  out  DISPATCH_W*INDEX  granted indices; lane k uses slice k.
- free_valid_i  in  ISSUE_W  per-lane free strobe.
- free_idx_i  in  ISSUE_W*INDEX  indices being returned.
- flush_i  in  1  all IQ entries become free.
- ram_raddr_o  out  DISPATCH_W*INDEX  free-list RAM read addresses.
- ram_rdata_i  in  DISPATCH_W*INDEX  free-list RAM read data (combinational).
- ram_waddr_o  out  ISSUE_W*INDEX  free-list RAM write addresses.
- ram_wdata_o  out  ISSUE_W*INDEX  free-list RAM write data.
- ram_we_o  out  ISSUE_W  free-list RAM write enables.
- free_cnt_o  out  INDEX+1  free entries held.
- ready_o  out  1  initialisation complete.
- err_o  out  1  sticky overflow/underflow error.

Function
REQ-006 The block SHALL run a two-state FSM, INIT and RUN, and SHALL keep head, tail (INDEX bits each, wrapping mod DEPTH), count (INDEX+1 bits) and init_ptr.
REQ-007 In INIT, each cycle SHALL write RAM[init_ptr+k] = init_ptr+k on all ISSUE_W lanes (ram_we_o all ones) and then advance init_ptr by ISSUE_W.
REQ-008 After the write group with init_ptr = DEPTH-ISSUE_W, the next state SHALL be RUN with head=0, tail=0, count=DEPTH; INIT therefore lasts DEPTH/ISSUE_W cycles.
REQ-009 In INIT: stall_o=1, ready_o=0, free_cnt_o=0; free_valid_i and alloc_cnt_i are ignored.
REQ-010 ram_raddr_o lane k SHALL always equal head+k mod DEPTH, and alloc_idx_o lane k SHALL equal ram_rdata_i lane k.
REQ-011 In RUN, stall_o SHALL be 1 iff alloc_cnt_i > count; this is a combinational, all-or-nothing grant.
REQ-012 In RUN, when alloc_cnt_i = n ≤ count and n > 0, the allocation SHALL be granted: lanes 0..n-1 are valid, head advances by n, and lanes ≥ n are don't-care.
REQ-013 In RUN, the valid free lanes SHALL be compacted in lane order. The j-th set lane writes free_idx_i to RAM[tail+j]; ram_we_o[j] is set for j < popcount(free_valid_i); tail advances by the popcount.
REQ-014 When allocation and free occur in the same cycle, both SHALL be performed:
- count_next = count + nfree - nalloc.
- Freed indices are not allocatable until the next cycle.
- The stall decision uses pre-update count only.
REQ-015 If count + nfree - nalloc would exceed DEPTH, err_o SHALL set and remain set until reset, and count SHALL saturate at DEPTH.
REQ-016 If an allocation is attempted while alloc_cnt_i > DISPATCH_W, err_o SHALL set and the request SHALL be treated as stalled.
REQ-017 free_cnt_o SHALL equal the registered count in RUN.
REQ-018 flush_i in RUN SHALL move the FSM to INIT next cycle with init_ptr=0; allocations and frees in the flush cycle SHALL be discarded (stall_o=1, ram_we_o=0).
REQ-019 flush_i in INIT SHALL restart init_ptr at 0.
REQ-020 Pointer wrap SHALL be natural INDEX-bit overflow; no full/empty ambiguity exists because count is held separately.

Reset
REQ-021 While reset_n is low:
- State is INIT, init_ptr=0, head=tail=0, count=0, err_o=0.
- ram_we_o=0 (gated by reset_n), stall_o=1, ready_o=0, free_cnt_o=0.
REQ-022 Reset assertion mid-INIT or mid-RUN SHALL abort immediately (asynchronous); on release, INIT restarts from init_ptr=0.

Verification
REQ-023 Release reset -> 4 cycles with ram_we_o=4'b1111 writing RAM 0..15 = 0..15, then ready_o=1, free_cnt_o=16.
REQ-024 RUN, alloc_cnt_i=4 for 4 cycles -> indices 0-3, 4-7, 8-11, 12-15, then free_cnt_o=0; fifth request with alloc_cnt_i=1 -> stall_o=1.
REQ-025 count=0, free_valid_i=4'b1010 with free_idx_i lanes 1,3 = 7,2 -> RAM[0]=7, RAM[1]=2, tail=2, free_cnt_o=2 next cycle, and same-cycle alloc_cnt_i=1 stalls.
REQ-026 head=tail=14, count=16 wrap case: alloc 3 -> read addresses 14,15,0,1 (lane 3 don't-care), head=1; free 3 in same cycle -> writes 14,15,0, count stays 16.
REQ-027 count=16, free_valid_i=4'b0001 -> err_o=1 and stays 1, free_cnt_o stays 16.
REQ-028 flush_i during RUN with count=5 -> stall_o=1 that cycle, 4-cycle INIT rerun, then free_cnt_o=16, head=0; reset_n pulsed low mid-INIT -> INIT restarts from init_ptr=0.
